// File: rtl/bus_pkg.sv
// ---------------------------------------------------------------------------
// bus_pkg: shared FSM encoding and field widths for the burst slave RAM. Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package bus_pkg;

  localparam int BURST_W = 8;
  localparam int BE_W    = 4;

  typedef enum logic [2:0] {
    S_IDLE        = 3'd0,
    S_READ_SETUP  = 3'd1,
    S_READ_BURST  = 3'd2,
    S_WRITE_BURST = 3'd3,
    S_END         = 3'd4,
    S_ERROR_END   = 3'd5
  } state_t;

endpackage

`default_nettype wire

// File: rtl/bus_slave_sram.sv
// ---------------------------------------------------------------------------
// bus_slave_sram: single-port synchronous RAM, byte write enables, registered read. Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module bus_slave_sram
  import bus_pkg::*;
#(
  parameter int addressWidth = 10
) (
  input  logic                    clock,
  input  logic [addressWidth-1:0] address,
  input  logic [BE_W-1:0]         writeEnable,
  input  logic [31:0]             dataIn,
  output logic [31:0]             dataOut
);

  logic [31:0] mem [2**addressWidth];

  // Read returns the word as it was before any same-cycle write.
  always_ff @(posedge clock) begin
    for (int b = 0; b < BE_W; b++) begin
      if (writeEnable[b]) mem[address][8*b +: 8] <= dataIn[8*b +: 8];
    end
    dataOut <= mem[address];
  end

endmodule

`default_nettype wire

// File: rtl/bus_burst_slave_ram.sv
// ---------------------------------------------------------------------------
// bus_burst_slave_ram: windowed burst read/write target on the multiplexed bus. Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module bus_burst_slave_ram
  import bus_pkg::*;
#(
  parameter logic [31:0] baseAddress  = 32'h5000_0000,
  parameter int          addressWidth = 10
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               beginTransactionIn,
  input  logic [31:0]        addressDataIn,
  input  logic               readNotWriteIn,
  input  logic [BURST_W-1:0] burstSizeIn,
  input  logic [BE_W-1:0]    byteEnablesIn,
  input  logic               dataValidIn,
  input  logic               endTransactionIn,
  input  logic               busErrorIn,
  output logic [31:0]        addressDataOut,
  output logic               dataValidOut,
  output logic               endTransactionOut,
  output logic               busErrorOut,
  output logic               busyOut
);

  localparam logic [addressWidth-1:0] IDX_ONE  = 1;
  localparam logic [BURST_W:0]        BEAT_ONE = 1;

  state_t                  state;
  logic [addressWidth-1:0] index;
  logic [BURST_W:0]        beats_left;
  logic                    data_valid;
  logic                    end_pulse;
  logic                    err_pulse;

  logic                    abort;
  logic                    select;
  logic                    addr_err;
  logic [addressWidth-1:0] req_index;
  logic [BURST_W:0]        req_beats;
  logic [31:0]             req_end;
  logic [BE_W-1:0]         ram_we;
  logic [31:0]             ram_rdata;

  assign abort     = endTransactionIn | busErrorIn;
  assign select    = beginTransactionIn &&
                     (addressDataIn[31:addressWidth+2] == baseAddress[31:addressWidth+2]);
  assign req_index = addressDataIn[addressWidth+1:2];
  assign req_beats = {1'b0, burstSizeIn} + BEAT_ONE;
  assign req_end   = 32'(req_index) + 32'(req_beats);
  // Bursts never wrap around the window end.
  assign addr_err  = (addressDataIn[1:0] != 2'b00) || (req_end > (32'd1 << addressWidth));

  // An aborting cycle discards the beat it carries.
  assign ram_we = (state == S_WRITE_BURST && dataValidIn && !abort) ? byteEnablesIn : '0;

  bus_slave_sram #(
    .addressWidth(addressWidth)
  ) u_sram (
    .clock      (clock),
    .address    (index),
    .writeEnable(ram_we),
    .dataIn     (addressDataIn),
    .dataOut    (ram_rdata)
  );

  // RAM output is a register; gating with the registered valid keeps the bus quiet.
  assign addressDataOut    = data_valid ? ram_rdata : 32'd0;
  assign dataValidOut      = data_valid;
  assign endTransactionOut = end_pulse;
  assign busErrorOut       = err_pulse;
  assign busyOut           = (state != S_IDLE);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state      <= S_IDLE;
      index      <= '0;
      beats_left <= '0;
      data_valid <= 1'b0;
      end_pulse  <= 1'b0;
      err_pulse  <= 1'b0;
    end else if (state != S_IDLE && abort) begin
      state      <= S_IDLE;
      data_valid <= 1'b0;
      end_pulse  <= 1'b0;
      err_pulse  <= 1'b0;
    end else begin
      end_pulse <= 1'b0;
      err_pulse <= 1'b0;
      case (state)
        S_IDLE: begin
          if (select) begin
            index      <= req_index;
            beats_left <= req_beats;
            if (addr_err)            state <= S_ERROR_END;
            else if (readNotWriteIn) state <= S_READ_SETUP;
            else                     state <= S_WRITE_BURST;
          end
        end
        S_READ_SETUP: begin
          index      <= index + IDX_ONE;
          beats_left <= beats_left - BEAT_ONE;
          data_valid <= 1'b1;
          state      <= S_READ_BURST;
        end
        S_READ_BURST: begin
          // beats_left counts reads still to issue behind the beat on the bus.
          if (beats_left == '0) begin
            data_valid <= 1'b0;
            end_pulse  <= 1'b1;
            state      <= S_END;
          end else begin
            index      <= index + IDX_ONE;
            beats_left <= beats_left - BEAT_ONE;
          end
        end
        S_WRITE_BURST: begin
          if (dataValidIn) begin
            index      <= index + IDX_ONE;
            beats_left <= beats_left - BEAT_ONE;
            if (beats_left == BEAT_ONE) begin
              end_pulse <= 1'b1;
              state     <= S_END;
            end
          end
        end
        S_END: state <= S_IDLE;
        S_ERROR_END: begin
          end_pulse <= 1'b1;
          err_pulse <= 1'b1;
          state     <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_bus_burst_slave_ram.sv
// ---------------------------------------------------------------------------
// tb_bus_burst_slave_ram: directed and random bursts against a word-array memory model. Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_bus_burst_slave_ram;

  logic        clock;
  logic        reset;
  logic        beginTransactionIn;
  logic [31:0] addressDataIn;
  logic        readNotWriteIn;
  logic [7:0]  burstSizeIn;
  logic [3:0]  byteEnablesIn;
  logic        dataValidIn;
  logic        endTransactionIn;
  logic        busErrorIn;
  logic [31:0] addressDataOut;
  logic        dataValidOut;
  logic        endTransactionOut;
  logic        busErrorOut;
  logic        busyOut;

  int checks;
  int failures;

  // Reference memory: word contents plus which bytes hold known values.
  logic [31:0] model [1024];
  logic [3:0]  wmask [1024];
  logic [31:0] wdata [256];
  logic [3:0]  wbe   [256];

  bus_burst_slave_ram dut (
    .clock             (clock),
    .reset             (reset),
    .beginTransactionIn(beginTransactionIn),
    .addressDataIn     (addressDataIn),
    .readNotWriteIn    (readNotWriteIn),
    .burstSizeIn       (burstSizeIn),
    .byteEnablesIn     (byteEnablesIn),
    .dataValidIn       (dataValidIn),
    .endTransactionIn  (endTransactionIn),
    .busErrorIn        (busErrorIn),
    .addressDataOut    (addressDataOut),
    .dataValidOut      (dataValidOut),
    .endTransactionOut (endTransactionOut),
    .busErrorOut       (busErrorOut),
    .busyOut           (busyOut)
  );

  always #5 clock = ~clock;

  initial begin
    #500_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  function automatic logic [31:0] bytemask(input logic [3:0] m);
    logic [31:0] r;
    for (int b = 0; b < 4; b++) r[8*b +: 8] = {8{m[b]}};
    return r;
  endfunction

  function automatic bit exp_err(input logic [31:0] addr, input int beats);
    return (addr[1:0] != 2'b00) || (int'(addr[11:2]) + beats > 1024);
  endfunction

  task automatic model_write(input int w, input logic [31:0] d, input logic [3:0] be);
    for (int b = 0; b < 4; b++) begin
      if (be[b]) begin
        model[w][8*b +: 8] = d[8*b +: 8];
        wmask[w][b] = 1'b1;
      end
    end
  endtask

  task automatic begin_txn(input logic [31:0] addr, input logic rnw, input int beats);
    beginTransactionIn = 1'b1;
    addressDataIn      = addr;
    readNotWriteIn     = rnw;
    burstSizeIn        = 8'(beats - 1);
    step();
    beginTransactionIn = 1'b0;
    addressDataIn      = 32'd0;
    readNotWriteIn     = 1'b0;
    burstSizeIn        = 8'd0;
  endtask

  task automatic check_quiet(input string tag);
    chk({tag, "_dv"},   32'(dataValidOut), 32'd0);
    chk({tag, "_data"}, addressDataOut, 32'd0);
    chk({tag, "_end"},  32'(endTransactionOut), 32'd0);
    chk({tag, "_err"},  32'(busErrorOut), 32'd0);
    chk({tag, "_busy"}, 32'(busyOut), 32'd0);
  endtask

  task automatic write_burst(input logic [31:0] addr, input int beats, input int maxgap);
    int w;
    w = int'(addr[11:2]);
    begin_txn(addr, 1'b0, beats);
    chk("wr_busy", 32'(busyOut), 32'd1);
    for (int i = 0; i < beats; i++) begin
      int g;
      g = $urandom_range(0, maxgap);
      for (int k = 0; k < g; k++) begin
        dataValidIn   = 1'b0;
        addressDataIn = $urandom;
        step();
        chk("wr_gap_end", 32'(endTransactionOut), 32'd0);
      end
      dataValidIn   = 1'b1;
      addressDataIn = wdata[i];
      byteEnablesIn = wbe[i];
      step();
      model_write(w + i, wdata[i], wbe[i]);
      dataValidIn   = 1'b0;
      addressDataIn = 32'd0;
      if (i < beats - 1) chk("wr_mid_end", 32'(endTransactionOut), 32'd0);
    end
    chk("wr_end", 32'(endTransactionOut), 32'd1);
    chk("wr_err", 32'(busErrorOut), 32'd0);
    chk("wr_dv",  32'(dataValidOut), 32'd0);
    // A beat offered after the last one must be dropped.
    dataValidIn   = 1'b1;
    addressDataIn = $urandom;
    byteEnablesIn = 4'hF;
    step();
    dataValidIn   = 1'b0;
    byteEnablesIn = 4'h0;
    chk("wr_end_clr", 32'(endTransactionOut), 32'd0);
    chk("wr_idle",    32'(busyOut), 32'd0);
  endtask

  task automatic read_burst(input logic [31:0] addr, input int beats, input int abort_at);
    int w;
    w = int'(addr[11:2]);
    begin_txn(addr, 1'b1, beats);
    chk("rd_setup_dv", 32'(dataValidOut), 32'd0);
    chk("rd_busy",     32'(busyOut), 32'd1);
    step();
    for (int i = 0; i < beats; i++) begin
      logic [31:0] m;
      m = bytemask(wmask[w + i]);
      chk("rd_dv", 32'(dataValidOut), 32'd1);
      chk("rd_end_early", 32'(endTransactionOut), 32'd0);
      if (m != 32'd0) chk("rd_data", addressDataOut & m, model[w + i] & m);
      if (i == abort_at) begin
        endTransactionIn = 1'b1;
        step();
        endTransactionIn = 1'b0;
        check_quiet("abort");
        return;
      end
      step();
    end
    chk("rd_end",      32'(endTransactionOut), 32'd1);
    chk("rd_err",      32'(busErrorOut), 32'd0);
    chk("rd_dv_off",   32'(dataValidOut), 32'd0);
    chk("rd_data_off", addressDataOut, 32'd0);
    step();
    chk("rd_end_clr", 32'(endTransactionOut), 32'd0);
    chk("rd_idle",    32'(busyOut), 32'd0);
  endtask

  task automatic error_txn(input logic [31:0] addr, input logic rnw, input int beats);
    begin_txn(addr, rnw, beats);
    chk("er_t1_err",  32'(busErrorOut), 32'd0);
    chk("er_t1_end",  32'(endTransactionOut), 32'd0);
    chk("er_t1_busy", 32'(busyOut), 32'd1);
    dataValidIn   = 1'b1;
    addressDataIn = 32'hDEAD_BEEF;
    byteEnablesIn = 4'hF;
    step();
    dataValidIn   = 1'b0;
    addressDataIn = 32'd0;
    byteEnablesIn = 4'h0;
    chk("er_err", 32'(busErrorOut), 32'd1);
    chk("er_end", 32'(endTransactionOut), 32'd1);
    chk("er_dv",  32'(dataValidOut), 32'd0);
    step();
    check_quiet("er_after");
  endtask

  initial begin
    checks = 0;
    failures = 0;
    for (int i = 0; i < 1024; i++) begin
      model[i] = 32'd0;
      wmask[i] = 4'h0;
    end
    clock = 1'b0;
    reset = 1'b1;
    beginTransactionIn = 1'b0;
    addressDataIn      = 32'd0;
    readNotWriteIn     = 1'b0;
    burstSizeIn        = 8'd0;
    byteEnablesIn      = 4'h0;
    dataValidIn        = 1'b0;
    endTransactionIn   = 1'b0;
    busErrorIn         = 1'b0;
    repeat (2) step();
    check_quiet("reset");
    reset = 1'b0;
    step();

    // Four-beat write then read-back of 1..4.
    for (int i = 0; i < 4; i++) begin
      wdata[i] = 32'(i + 1);
      wbe[i]   = 4'hF;
    end
    write_burst(32'h5000_0000, 4, 0);
    read_burst(32'h5000_0000, 4, -1);

    // Partial-byte overwrite merges into the earlier word.
    wdata[0] = 32'h1122_3344; wbe[0] = 4'hF;
    write_burst(32'h5000_0010, 1, 0);
    wdata[0] = 32'hAABB_CCDD; wbe[0] = 4'b0011;
    write_burst(32'h5000_0010, 1, 0);
    chk("merge_model", model[4], 32'h1122_CCDD);
    read_burst(32'h5000_0010, 1, -1);

    // Window-end overrun: both directions, data left intact.
    wdata[0] = 32'h5A5A_0FFC; wbe[0] = 4'hF;
    write_burst(32'h5000_0FFC, 1, 0);
    error_txn(32'h5000_0FFC, 1'b1, 2);
    error_txn(32'h5000_0FFC, 1'b0, 2);
    read_burst(32'h5000_0FFC, 1, -1);

    // Unselected window, then misaligned address.
    begin_txn(32'h4000_0000, 1'b1, 4);
    for (int k = 0; k < 3; k++) begin
      check_quiet("unsel");
      step();
    end
    error_txn(32'h5000_0002, 1'b1, 1);

    // Gapped eight-beat write.
    for (int i = 0; i < 8; i++) begin
      wdata[i] = $urandom;
      wbe[i]   = 4'hF;
    end
    write_burst(32'h5000_0100, 8, 3);
    read_burst(32'h5000_0100, 8, -1);

    // Master abort in the middle of a long read.
    read_burst(32'h5000_0000, 16, 3);

    // Asynchronous reset during a read burst.
    begin_txn(32'h5000_0000, 1'b1, 16);
    repeat (3) step();
    chk("pre_reset_dv", 32'(dataValidOut), 32'd1);
    reset = 1'b1;
    #1;
    check_quiet("async_reset");
    @(negedge clock);
    reset = 1'b0;
    step();
    read_burst(32'h5000_0000, 4, -1);

    // Random traffic checked against the model.
    for (int n = 0; n < 30; n++) begin
      int idx;
      int beats;
      logic [31:0] addr;
      idx   = ($urandom_range(0, 3) == 0) ? int'($urandom_range(990, 1023)) : int'($urandom_range(0, 1023));
      beats = $urandom_range(1, 24);
      addr  = {20'h50000, 10'(idx), 2'b00};
      if (exp_err(addr, beats)) begin
        error_txn(addr, 1'($urandom_range(0, 1)), beats);
      end else if ($urandom_range(0, 1) == 1) begin
        read_burst(addr, beats, -1);
      end else begin
        for (int i = 0; i < beats; i++) begin
          wdata[i] = $urandom;
          wbe[i]   = 4'($urandom_range(0, 15));
        end
        write_burst(addr, beats, 2);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
